// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the architectural PC, issues one instruction-memory request per
// instruction and presents {Cur_PC, Instr} to decode. The presentation stage is
// one output register plus a one-entry skid buffer. A taken branch (PcSel)
// redirects the PC, drops wrong-path work and pulses Flush for one cycle.
//
// Handshake semantics (both interfaces):
//   imem: imem_req/imem_addr are raised by this block and held stable until the
//         cycle imem_ack is high; the transfer completes in that cycle with
//         imem_rdata valid alongside imem_ack. A request is only ever withdrawn
//         by reset, and memory abandons anything outstanding on reset.
//   decode: instr_valid is the valid, !Stall is the ready; an entry is consumed
//         at an edge where instr_valid && !Stall. Unconsumed entries hold.
module fetch_unit #(
  parameter int unsigned     PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] Cur_PC,
  output logic [31:0]     Instr,
  output logic            instr_valid,
  output logic            Flush,
  output logic [1:0]      o_dbg_state
);

  // REQ : requesting the instruction at r_pc.
  // HOLD: skid buffer is full, waiting for the output register to free.
  // DROP: an already-issued wrong-path request is still waiting for its ack.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_stale_addr;
  logic [PC_W-1:0] r_skid_pc;
  logic [31:0]     r_skid_instr;
  logic [PC_W-1:0] r_cur_pc;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic            r_flush;

  logic            w_can_accept;
  logic            w_consume;
  logic            w_req;
  logic [PC_W-1:0] w_addr;
  logic            w_load_out;
  logic            w_load_skid;
  logic            w_move_skid;
  logic            w_pc_inc;
  logic            w_save_stale;
  logic [PC_W-1:0] w_target_pc;
  logic            w_unused_brpc;

  // Branch targets are forced to word alignment; high BrPC bits are ignored.
  assign w_target_pc   = {BrPC[PC_W-1:2], 2'b00};
  assign w_unused_brpc = &{1'b0, BrPC[31:PC_W], BrPC[1:0]};

  // Output register is free when empty or being consumed this edge.
  assign w_can_accept = !r_valid || !Stall;
  assign w_consume    = r_valid && !Stall;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_REQ;
    else       r_state <= w_next_state;
  end

  // Next-state logic, memory request outputs and datapath control strobes.
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_addr       = r_pc;
    w_load_out   = 1'b0;
    w_load_skid  = 1'b0;
    w_move_skid  = 1'b0;
    w_pc_inc     = 1'b0;
    w_save_stale = 1'b0;
    case (r_state)
      ST_REQ: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (PcSel) begin
          // Ack this cycle means the wrong-path word is simply not captured;
          // otherwise the request must be carried to its ack in DROP.
          if (!imem_ack) begin
            w_save_stale = 1'b1;
            w_next_state = ST_DROP;
          end
        end else if (imem_ack) begin
          w_pc_inc = 1'b1;
          if (w_can_accept) begin
            w_load_out = 1'b1;
          end else begin
            w_load_skid  = 1'b1;
            w_next_state = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (PcSel) begin
          w_next_state = ST_REQ;
        end else if (w_can_accept) begin
          w_move_skid  = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      ST_DROP: begin
        w_req  = 1'b1;
        w_addr = r_stale_addr;
        if (imem_ack) w_next_state = ST_REQ;
      end
      default: w_next_state = ST_REQ;
    endcase
  end

  // PC, stale address, skid buffer, output register and Flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_stale_addr <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_cur_pc     <= '0;
      r_instr      <= NOP_INSTR;
      r_valid      <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_flush <= PcSel;
      if (PcSel) begin
        // Redirect wins over Stall and over any returning data.
        r_pc         <= w_target_pc;
        r_valid      <= 1'b0;
        r_instr      <= NOP_INSTR;
        r_skid_pc    <= '0;
        r_skid_instr <= '0;
        if (w_save_stale) r_stale_addr <= r_pc;
      end else begin
        if (w_pc_inc) r_pc <= r_pc + PC_W'(4);
        if (w_load_skid) begin
          r_skid_pc    <= r_pc;
          r_skid_instr <= imem_rdata;
        end
        if (w_load_out) begin
          r_cur_pc <= r_pc;
          r_instr  <= imem_rdata;
          r_valid  <= 1'b1;
        end else if (w_move_skid) begin
          r_cur_pc     <= r_skid_pc;
          r_instr      <= r_skid_instr;
          r_valid      <= 1'b1;
          r_skid_pc    <= '0;
          r_skid_instr <= '0;
        end else if (w_consume) begin
          r_valid <= 1'b0;
          r_instr <= NOP_INSTR;
        end
      end
    end
  end

  // Request is suppressed combinationally during reset so memory sees no
  // request in the reset cycle.
  assign imem_req    = w_req && !reset;
  assign imem_addr   = w_addr;
  assign Cur_PC      = r_cur_pc;
  assign Instr       = r_instr;
  assign instr_valid = r_valid;
  assign Flush       = r_flush;
  assign o_dbg_state = r_state;

endmodule
